// File: rtl/button_conditioner.sv
// Push-button front end: synchronise, debounce, and emit level/press/release per button.
// Optional auto-repeat on masked buttons when BUTTON_CONDITIONER_AUTOREPEAT_EN is defined.
module button_conditioner #(
  parameter int              N_BTN           = 4,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 20000,
  parameter int              REPEAT_DELAY    = 50000,
  parameter int              REPEAT_PERIOD   = 10000,
  parameter logic [N_BTN-1:0] REPEAT_MASK    = 4'b1100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
      $countones(REPEAT_MASK) > N_BTN) begin : g_param_check
    $error("button_conditioner: illegal parameter value");
  end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  localparam int               REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RCNT_W   = $clog2(REP_MAX + 1);
  localparam logic [RCNT_W-1:0] RDLY_TC = RCNT_W'(REPEAT_DELAY);
  localparam logic [RCNT_W-1:0] RPER_TC = RCNT_W'(REPEAT_PERIOD);
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   stable_q;
    logic                   pulse_q;
    logic                   release_q;
    logic                   sync_out;
    logic                   accept;
    logic                   press;
    logic                   rel;

    assign sync_out = sync_q[SYNC_STAGES-1];
    // accept fires on the edge where the incremented count would hit the terminal value
    assign accept   = (sync_out != stable_q) && ((cnt_q + CNT_W'(1)) == CNT_TERM);
    assign press    = accept & sync_out;
    assign rel      = accept & ~sync_out;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q    <= '0;
        cnt_q     <= '0;
        stable_q  <= 1'b0;
        release_q <= 1'b0;
      end else begin
        sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
        release_q <= rel;
        if (sync_out == stable_q) begin
          cnt_q <= '0;
        end else if (accept) begin
          stable_q <= sync_out;
          cnt_q    <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    if (REPEAT_MASK[i]) begin : g_rep
      rep_state_e        state_q;
      logic [RCNT_W-1:0] rcnt_q;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= ST_IDLE;
          rcnt_q  <= '0;
          pulse_q <= 1'b0;
        end else begin
          pulse_q <= press;
          case (state_q)
            ST_IDLE: begin
              if (press) begin
                state_q <= ST_HELD;
                rcnt_q  <= '0;
              end
            end
            ST_HELD: begin
              if (rel) begin
                state_q <= ST_IDLE;
                rcnt_q  <= '0;
              end else if ((rcnt_q + RCNT_W'(1)) == RDLY_TC) begin
                pulse_q <= 1'b1;
                rcnt_q  <= '0;
                state_q <= ST_REPEAT;
              end else begin
                rcnt_q <= rcnt_q + RCNT_W'(1);
              end
            end
            ST_REPEAT: begin
              if (rel) begin
                state_q <= ST_IDLE;
                rcnt_q  <= '0;
              end else if ((rcnt_q + RCNT_W'(1)) == RPER_TC) begin
                pulse_q <= 1'b1;
                rcnt_q  <= '0;
              end else begin
                rcnt_q <= rcnt_q + RCNT_W'(1);
              end
            end
            default: begin
              state_q <= ST_IDLE;
              rcnt_q  <= '0;
            end
          endcase
        end
      end
    end else begin : g_norep
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) pulse_q <= 1'b0;
        else        pulse_q <= press;
      end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) pulse_q <= 1'b0;
      else        pulse_q <= press;
    end
`endif

    assign btn_level[i]   = stable_q;
    assign btn_pulse[i]   = pulse_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed plus randomised bench for button_conditioner, checked every cycle against
// an event-level reference model (delayed raw samples, run lengths, elapsed-time repeats).
module tb_button_conditioner;

  localparam int         S     = 2;
  localparam int         DEB   = 4;
  localparam int         RDLY  = 8;
  localparam int         RPER  = 3;
  localparam logic [3:0] RMASK = 4'b1100;
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] btn_raw = 4'b0;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [3:0] btn_release;

  button_conditioner #(
    .N_BTN          (4),
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER),
    .REPEAT_MASK    (RMASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  logic [3:0] hist[$];
  logic [3:0] m_stable;
  logic [3:0] m_pulse;
  logic [3:0] m_release;
  int         run[4];
  int         acc_t[4];

  function automatic void model_clear();
    hist.delete();
    m_stable  = 4'b0;
    m_pulse   = 4'b0;
    m_release = 4'b0;
    for (int i = 0; i < 4; i++) begin
      run[i]   = 0;
      acc_t[i] = 0;
    end
  endfunction

  // Raw level seen by the debouncer is the raw sample taken S edges earlier.
  function automatic void model_edge();
    logic [3:0] so;
    int el;
    so = (hist.size() >= S) ? hist[hist.size()-S] : 4'b0;
    m_pulse   = 4'b0;
    m_release = 4'b0;
    for (int i = 0; i < 4; i++) begin
      if (so[i] != m_stable[i]) begin
        run[i]++;
        if (run[i] == DEB) begin
          m_stable[i] = so[i];
          run[i] = 0;
          if (so[i]) begin
            m_pulse[i] = 1'b1;
            acc_t[i] = edge_n;
          end else begin
            m_release[i] = 1'b1;
          end
        end
      end else begin
        run[i] = 0;
      end
      if (AR && RMASK[i] && m_stable[i] && !m_pulse[i]) begin
        el = edge_n - acc_t[i];
        if (el == RDLY || (el > RDLY && ((el - RDLY) % RPER) == 0)) m_pulse[i] = 1'b1;
      end
    end
    hist.push_back(btn_raw);
    if (hist.size() > S) void'(hist.pop_front());
    edge_n++;
  endfunction

  task automatic check();
    vectors++;
    assert (btn_level === m_stable) else begin
      miscompares++;
      $error("FAIL level edge=%0d got=%b exp=%b", edge_n, btn_level, m_stable);
    end
    vectors++;
    assert (btn_pulse === m_pulse) else begin
      miscompares++;
      $error("FAIL pulse edge=%0d got=%b exp=%b", edge_n, btn_pulse, m_pulse);
    end
    vectors++;
    assert (btn_release === m_release) else begin
      miscompares++;
      $error("FAIL release edge=%0d got=%b exp=%b", edge_n, btn_release, m_release);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!reset) model_clear();
      else        model_edge();
      #1;
      check();
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    model_clear();
    #1;
    check();
    step(1);
    reset = 1'b1;
  endtask

  initial begin
    model_clear();
    // Reset held with all buttons pressed
    btn_raw = 4'b1111;
    #1;
    check();
    step(3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
    step(8);
    btn_raw = 4'b0000;
    step(10);

    // Clean op1 press and release
    btn_raw = 4'b0100;
    step(20);
    btn_raw = 4'b0000;
    step(10);

    // Bounce on set: 2-cycle runs never reach the debounce count
    for (int r = 0; r < 4; r++) begin
      btn_raw = (r % 2 == 0) ? 4'b0010 : 4'b0000;
      step(2);
    end
    btn_raw = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      step(1);
      vectors++;
      assert (btn_level[1] === 1'b0 && btn_pulse[1] === 1'b0) else begin
        miscompares++;
        $error("FAIL bounce_set level=%b pulse=%b exp=0", btn_level[1], btn_pulse[1]);
      end
    end

    // Simultaneous mode+set, reset mid-count, then full re-accept
    btn_raw = 4'b0011;
    step(4);
    reset_pulse();
    step(8);
    btn_raw = 4'b0000;
    step(10);

    // op2 (repeat-eligible) and set (masked out) held well past accept
    btn_raw = 4'b1010;
    step(5 + 30);
    btn_raw = 4'b0000;
    step(15);

    // Randomised toggling with occasional async reset
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_pulse();
      end else begin
        if ($urandom_range(0, 5) == 0) btn_raw = btn_raw ^ 4'($urandom_range(1, 15));
        step(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
